vec_regfile: RTL
================

VEC_REGFILE -- requirements
Module: vec_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of vector registers (power of two, >=2).
REQ-002 SHALL have parameter LANES, default 16, lanes per vector.
REQ-003 SHALL have parameter LANE_W, default 32, bits per lane; VEC_W = LANES*LANE_W, ADDR_W = clog2(NUM_REGS).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port op_valid  input  1  operation request.
REQ-007 SHALL have port op_ready  output  1  block can accept an operation.
REQ-008 SHALL have port op_code  input  2  00 WRITE, 01 ADD, 10 SUB, 11 MUL.
REQ-009 SHALL have ports src_a, src_b, dst  input  ADDR_W each  operand and destination registers.
REQ-010 SHALL have port write_data  input  VEC_W  data for WRITE.
REQ-011 SHALL have port read_addr  input  ADDR_W  independent read port address.
REQ-012 SHALL have port read_data  output  VEC_W  registered read data.
REQ-013 SHALL have port busy  output  1  multi-cycle MUL in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when an operation's result is written.

Function
REQ-015 SHALL accept an operation only on a cycle with op_valid=1 and op_ready=1; op_ready=1 exactly in state IDLE.
REQ-016 SHALL execute WRITE in one cycle: regs[dst] <= write_data on the accepting edge, done=1 next cycle.
REQ-017 SHALL execute ADD/SUB lane-wise in one cycle, each lane modulo 2^LANE_W, result to regs[dst], done=1 next cycle.
REQ-018 SHALL execute MUL as unsigned lane-wise LANE_W x LANE_W -> 2*LANE_W: low halves to regs[dst], high halves to regs[(dst+1) mod NUM_REGS].
REQ-019 SHALL implement MUL with FSM IDLE -> MUL -> WB -> IDLE; MUL computes one lane per cycle for LANES cycles (lane counter 0..LANES-1), WB writes both registers in one cycle.
REQ-020 SHALL latch src_a/src_b contents and dst on acceptance; later register changes and input changes do not affect the running MUL.
REQ-021 SHALL hold busy=1 in MUL and WB; done pulses on the cycle after WB; total MUL latency LANES+2 cycles from acceptance to done.
REQ-022 SHALL update read_data <= regs[read_addr] every cycle (1-cycle latency), including while busy.
REQ-023 SHALL return the pre-write value when read_addr equals a register written on the same edge (read-before-write).
REQ-024 SHALL handle src_a==src_b and dst==src correctly, since operands are sampled before write-back.
REQ-025 SHALL wrap dst+1 to register 0 when dst = NUM_REGS-1.
REQ-026 SHALL ignore op_valid while op_ready=0; no queueing.

Reset
REQ-027 SHALL, when rst=0 at a rising edge, clear all registers, read_data, lane counter, busy and done to 0 and enter IDLE (op_ready=1 on the first cycle after rst returns to 1).
REQ-028 SHALL abort an in-flight MUL on reset with no partial write-back beyond the reset clearing.

Configuration
REQ-029 SHALL, with macro VEC_REGFILE_SATURATE_EN defined, saturate ADD lanes at 2^LANE_W-1 and SUB lanes at 0 (unsigned).
REQ-030 SHALL, without VEC_REGFILE_SATURATE_EN, wrap ADD/SUB modulo 2^LANE_W; MUL and WRITE unaffected either way.

Verification (defaults: NUM_REGS=4, LANES=16, LANE_W=32)
REQ-031 Reset: hold rst=0 two cycles after arbitrary writes -> read_data=0 for all four addresses, op_ready=1, busy=0.
REQ-032 WRITE/read: WRITE dst=2 data=123456, read_addr=2 on the same cycle -> read_data=0 next cycle, 123456 one cycle later.
REQ-033 ADD: r0 lanes=12, r1 lanes=11, ADD a=0 b=1 dst=2 -> r2 all lanes 23; r0 lane0=0xFFFFFFFF, r1 lane0=1 -> lane0 0 (0xFFFFFFFF with SATURATE_EN).
REQ-034 MUL: r0 lanes=0xFFFFFFFF, r1 lanes=2, MUL dst=3 -> done 18 cycles after accept, r3 lanes 0xFFFFFFFE, r0 lanes 1 (wrap), op_valid ignored while busy.
REQ-035 Reset mid-MUL: assert rst=0 at lane counter 5 -> all registers 0, no done pulse, next WRITE accepted normally.

Source files
------------

// File: rtl/vec_regfile.sv
// Vector register file with lane-wise WRITE/ADD/SUB (one cycle) and a sequential lane-by-lane MUL.
// Optional build macro VEC_REGFILE_SATURATE_EN makes ADD/SUB saturate (unsigned) instead of wrapping.
module vec_regfile #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned LANES    = 16,
  parameter int unsigned LANE_W   = 32,
  localparam int unsigned VEC_W   = LANES * LANE_W,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [VEC_W-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [VEC_W-1:0]  read_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LastLane = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    OpWrite = 2'b00,
    OpAdd   = 2'b01,
    OpSub   = 2'b10,
    OpMul   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StWb
  } state_e;

  state_e             state_q;
  logic [VEC_W-1:0]   regs_q [NUM_REGS];
  logic [VEC_W-1:0]   read_data_q;
  logic [VEC_W-1:0]   mul_a_q, mul_b_q;
  logic [VEC_W-1:0]   prod_lo_q, prod_hi_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [CNT_W-1:0]   lane_q;
  logic               busy_q, done_q;

  logic [VEC_W-1:0]   op_a, op_b, alu_d;
  logic [LANE_W-1:0]  a_l, b_l;
  logic [2*LANE_W-1:0] prod;
  logic [ADDR_W-1:0]  dst_hi;
`ifdef VEC_REGFILE_SATURATE_EN
  logic [LANE_W:0]    sum_l, diff_l;
`endif

  assign op_a = regs_q[src_a];
  assign op_b = regs_q[src_b];

  // Lane-wise ADD/SUB; the top bit of the extended sum/difference flags overflow/underflow.
  always_comb begin
    alu_d = '0;
    a_l   = '0;
    b_l   = '0;
`ifdef VEC_REGFILE_SATURATE_EN
    sum_l  = '0;
    diff_l = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
      a_l = op_a[l*LANE_W +: LANE_W];
      b_l = op_b[l*LANE_W +: LANE_W];
`ifdef VEC_REGFILE_SATURATE_EN
      sum_l  = {1'b0, a_l} + {1'b0, b_l};
      diff_l = {1'b0, a_l} - {1'b0, b_l};
      if (op_code == OpSub) begin
        alu_d[l*LANE_W +: LANE_W] = diff_l[LANE_W] ? '0 : diff_l[LANE_W-1:0];
      end else begin
        alu_d[l*LANE_W +: LANE_W] = sum_l[LANE_W] ? '1 : sum_l[LANE_W-1:0];
      end
`else
      alu_d[l*LANE_W +: LANE_W] = (op_code == OpSub) ? (a_l - b_l) : (a_l + b_l);
`endif
    end
  end

  // Operands shift right one lane per cycle, so the active lane is always at the bottom.
  assign prod   = (2*LANE_W)'(mul_a_q[LANE_W-1:0]) * (2*LANE_W)'(mul_b_q[LANE_W-1:0]);
  assign dst_hi = dst_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      state_q     <= StIdle;
      read_data_q <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      prod_lo_q   <= '0;
      prod_hi_q   <= '0;
      dst_q       <= '0;
      lane_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      read_data_q <= regs_q[read_addr];
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            unique case (op_e'(op_code))
              OpWrite: begin
                regs_q[dst] <= write_data;
                done_q      <= 1'b1;
              end
              OpAdd, OpSub: begin
                regs_q[dst] <= alu_d;
                done_q      <= 1'b1;
              end
              OpMul: begin
                mul_a_q <= op_a;
                mul_b_q <= op_b;
                dst_q   <= dst;
                lane_q  <= '0;
                busy_q  <= 1'b1;
                state_q <= StMul;
              end
              default: ;
            endcase
          end
        end
        StMul: begin
          mul_a_q   <= mul_a_q >> LANE_W;
          mul_b_q   <= mul_b_q >> LANE_W;
          prod_lo_q <= prod_lo_q >> LANE_W;
          prod_hi_q <= prod_hi_q >> LANE_W;
          prod_lo_q[VEC_W-LANE_W +: LANE_W] <= prod[LANE_W-1:0];
          prod_hi_q[VEC_W-LANE_W +: LANE_W] <= prod[2*LANE_W-1:LANE_W];
          lane_q <= lane_q + CNT_W'(1);
          if (lane_q == LastLane) begin
            state_q <= StWb;
          end
        end
        StWb: begin
          regs_q[dst_q]  <= prod_lo_q;
          regs_q[dst_hi] <= prod_hi_q;
          busy_q         <= 1'b0;
          done_q         <= 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign op_ready  = (state_q == StIdle);
  assign read_data = read_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
